pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage ARM pipeline. It detects read-after-write and load-use hazards in ID, drives the forwarding-enable policy for the operand-forwarding unit, and freezes the whole pipe while a MEM-stage SRAM access is outstanding. It also issues branch flushes and keeps optional performance counters. It sits beside the ID stage and drives the hold/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipeline_hazard_controller_if.sv | 51 +++++
 rtl/pipeline_hazard_controller.sv | 150 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// -----------------------------------------------------------------------------
// hazard_if
// Groups the pipeline-side signals of the hazard controller into one bundle.
//   master : pipeline / environment side. Drives the ID/EXE/MEM stage info,
//            the branch result and the SRAM handshake, and receives the
//            hold/flush controls.
//   slave  : pipeline_hazard_controller side.
// Inputs to the controller:
//   fwdMode, src1, src2, twoSrc, destEXE, wbEnEXE, memREnEXE, destMEM,
//   wbEnMEM, branchTaken, memReq, memReady
// Outputs from the controller:
//   forwardingEn, hazard, flush, freezeAll, memError, stallCycles, flushCount
// -----------------------------------------------------------------------------
interface hazard_if #(
    parameter int CNT_W = 32
);
    logic             fwdMode;
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic             twoSrc;
    logic [3:0]       destEXE;
    logic             wbEnEXE;
    logic             memREnEXE;
    logic [3:0]       destMEM;
    logic             wbEnMEM;
    logic             branchTaken;
    logic             memReq;
    logic             memReady;

    logic             forwardingEn;
    logic             hazard;
    logic             flush;
    logic             freezeAll;
    logic             memError;
    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] flushCount;

    modport master (
        output fwdMode, src1, src2, twoSrc, destEXE, wbEnEXE, memREnEXE,
               destMEM, wbEnMEM, branchTaken, memReq, memReady,
        input  forwardingEn, hazard, flush, freezeAll, memError,
               stallCycles, flushCount
    );

    modport slave (
        input  fwdMode, src1, src2, twoSrc, destEXE, wbEnEXE, memREnEXE,
               destMEM, wbEnMEM, branchTaken, memReq, memReady,
        output forwardingEn, hazard, flush, freezeAll, memError,
               stallCycles, flushCount
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
// Stall/flush sequencer for the 5-stage pipeline. Detects RAW and load-use
// hazards in ID, freezes the whole pipe while a MEM-stage SRAM access is
// outstanding, issues branch flushes and optionally counts stall/flush cycles.
//
// Ports:
//   clk    : pipeline clock, rising edge
//   rst    : asynchronous, active-high reset
//   hz_if  : hazard_if.slave bundle (stage info in, hold/flush controls out)
//
// Parameters:
//   MEM_TIMEOUT : MEM_WAIT cycles before the sticky memError flag is raised
//   CNT_W       : performance counter width (must match the interface CNT_W)
//
// Build option:
//   PERF_COUNTERS_EN : when defined, stallCycles/flushCount are saturating
//                      counters; when undefined both outputs are tied to 0.
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz_if
);

    // Wait counter is sized to hold MEM_TIMEOUT, clamped to 8..16 bits.
    localparam int WAIT_RAW = $clog2(MEM_TIMEOUT + 1);
    localparam int WAIT_W   = (WAIT_RAW < 8) ? 8 : ((WAIT_RAW > 16) ? 16 : WAIT_RAW);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    state_e            state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              mem_error_q;

    // ------------------------------------------------------------------
    // Hazard detection. src1 is always read by the ID instruction; src2
    // only when twoSrc is set. A stage only matches if it writes back.
    // ------------------------------------------------------------------
    logic raw_exe;
    logic raw_mem;
    logic hazard_raw;
    logic freeze_raw;

    assign raw_exe = hz_if.wbEnEXE &&
                     ((hz_if.src1 == hz_if.destEXE) ||
                      (hz_if.twoSrc && (hz_if.src2 == hz_if.destEXE)));

    assign raw_mem = hz_if.wbEnMEM &&
                     ((hz_if.src1 == hz_if.destMEM) ||
                      (hz_if.twoSrc && (hz_if.src2 == hz_if.destMEM)));

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign hazard_raw = hz_if.fwdMode ? (hz_if.memREnEXE && raw_exe)
                                      : (raw_exe || raw_mem);

    // Freeze starts in the same cycle the unanswered request appears.
    assign freeze_raw = (state_q == RUN) ? (hz_if.memReq && !hz_if.memReady)
                                         : !hz_if.memReady;

    // Priority freeze > flush > hazard. A frozen branch is held in EXE and
    // re-presents branchTaken once the freeze lifts, so dropping it is safe.
    assign hz_if.freezeAll    = !rst && freeze_raw;
    assign hz_if.flush        = !rst && !freeze_raw && hz_if.branchTaken;
    assign hz_if.hazard       = !rst && !freeze_raw && !hz_if.branchTaken && hazard_raw;
    assign hz_if.forwardingEn = hz_if.fwdMode;
    assign hz_if.memError     = mem_error_q;

    // ------------------------------------------------------------------
    // SRAM wait FSM with timeout watchdog.
    // ------------------------------------------------------------------
    logic [WAIT_W-1:0] wait_inc;
    assign wait_inc = wait_cnt_q + WAIT_W'(1);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz_if.memReq && !hz_if.memReady) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (hz_if.memReady) begin
                        state_q <= RUN;
                    end else if (wait_cnt_q != TIMEOUT_VAL) begin
                        // Counter saturates at the timeout; memError is sticky.
                        wait_cnt_q <= wait_inc;
                        if (wait_inc == TIMEOUT_VAL) begin
                            mem_error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional saturating performance counters.
    // ------------------------------------------------------------------
`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((hz_if.hazard || hz_if.freezeAll) && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (hz_if.flush && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz_if.stallCycles = stall_cnt_q;
    assign hz_if.flushCount  = flush_cnt_q;
`else
    assign hz_if.stallCycles = '0;
    assign hz_if.flushCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_controller
// Directed stimulus with hand-computed expectations. The stimulus process
// pushes expected output values into a queue tagged with the cycle they
// belong to; a monitor on the falling edge pops and compares them.
// Works with or without PERF_COUNTERS_EN defined.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 32;

    typedef enum int {
        SEL_HAZ, SEL_FLUSH, SEL_FRZ, SEL_ERR, SEL_STALL, SEL_FLCNT, SEL_FWDEN
    } sel_e;

    typedef struct {
        string       name;
        sel_e        sel;
        int          cyc;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    hazard_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_controller #(
        .MEM_TIMEOUT(8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .hz_if(hz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   failed    = 0;

    // Expected-state of the bench: running totals of hand-specified outputs.
    int   sc      = 0;
    int   fc      = 0;
    bit   exp_err = 1'b0;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    function automatic logic [31:0] actual(input sel_e s);
        case (s)
            SEL_HAZ:   return {31'd0, hz.hazard};
            SEL_FLUSH: return {31'd0, hz.flush};
            SEL_FRZ:   return {31'd0, hz.freezeAll};
            SEL_ERR:   return {31'd0, hz.memError};
            SEL_STALL: return hz.stallCycles;
            SEL_FLCNT: return hz.flushCount;
            default:   return {31'd0, hz.forwardingEn};
        endcase
    endfunction

    exp_t        mon_e;
    logic [31:0] mon_act;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e   = exp_q.pop_front();
            mon_act = actual(mon_e.sel);
            tests_run++;
            if (mon_e.cyc != cyc) begin
                failed++;
                $display("FAIL %s: expectation for cycle %0d sampled late at cycle %0d",
                         mon_e.name, mon_e.cyc, cyc);
            end else if (mon_act !== mon_e.val) begin
                failed++;
                $display("FAIL %s (%s): got %0d, expected %0d",
                         mon_e.name, mon_e.sel.name(), mon_act, mon_e.val);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push(input string name, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = s;
        e.cyc  = cyc;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Queue the expected outputs for the current cycle, then advance the
    // bench's counter totals by what this cycle should add.
    task automatic check(input string name, input bit h, input bit f, input bit z);
        push({name, ".hazard"},    SEL_HAZ,   {31'd0, h});
        push({name, ".flush"},     SEL_FLUSH, {31'd0, f});
        push({name, ".freezeAll"}, SEL_FRZ,   {31'd0, z});
        push({name, ".memError"},  SEL_ERR,   {31'd0, exp_err});
`ifdef PERF_COUNTERS_EN
        push({name, ".stallCycles"}, SEL_STALL, sc);
        push({name, ".flushCount"},  SEL_FLCNT, fc);
`else
        push({name, ".stallCycles"}, SEL_STALL, 32'd0);
        push({name, ".flushCount"},  SEL_FLCNT, 32'd0);
`endif
        if (h || z) sc++;
        if (f)      fc++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.src1        = 4'd0;
        hz.src2        = 4'd0;
        hz.twoSrc      = 1'b0;
        hz.destEXE     = 4'd0;
        hz.wbEnEXE     = 1'b0;
        hz.memREnEXE   = 1'b0;
        hz.destMEM     = 4'd0;
        hz.wbEnMEM     = 1'b0;
        hz.branchTaken = 1'b0;
        hz.memReq      = 1'b0;
        hz.memReady    = 1'b0;
    endtask

    task automatic apply_reset(input bit mode);
        step();
        rst        = 1'b1;
        hz.fwdMode = mode;
        sc         = 0;
        fc         = 0;
        exp_err    = 1'b0;
        check("reset", 1'b0, 1'b0, 1'b0);
        push("reset.fwden", SEL_FWDEN, {31'd0, mode});
        step();
        rst = 1'b0;
        clear_inputs();
        check("post_reset", 1'b0, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    initial begin
        hz.fwdMode = 1'b1;
        clear_inputs();

        // Reset with inputs that would otherwise raise every output.
        step();
        hz.fwdMode     = 1'b0;
        hz.wbEnEXE     = 1'b1;
        hz.destEXE     = 4'd3;
        hz.src1        = 4'd3;
        hz.branchTaken = 1'b1;
        hz.memReq      = 1'b1;
        check("rst_forced", 1'b0, 1'b0, 1'b0);
        apply_reset(1'b1);

        // Load-use with forwarding: one bubble, then the load sits in MEM.
        step();
        hz.wbEnEXE = 1'b1; hz.memREnEXE = 1'b1; hz.destEXE = 4'd3; hz.src1 = 4'd3;
        check("loaduse", 1'b1, 1'b0, 1'b0);
        step();
        hz.wbEnEXE = 1'b0; hz.memREnEXE = 1'b0; hz.destEXE = 4'd0;
        hz.wbEnMEM = 1'b1; hz.destMEM = 4'd3;
        check("loaduse_bubble", 1'b0, 1'b0, 1'b0);
        step();
        clear_inputs();
        hz.wbEnEXE = 1'b1; hz.destEXE = 4'd3; hz.src1 = 4'd3;
        check("fwd_alu_no_stall", 1'b0, 1'b0, 1'b0);

        // Stall-only operation.
        apply_reset(1'b0);
        step();
        hz.wbEnEXE = 1'b1; hz.destEXE = 4'd5; hz.src2 = 4'd5; hz.twoSrc = 1'b1;
        check("raw_exe_src2", 1'b1, 1'b0, 1'b0);
        step();
        hz.wbEnEXE = 1'b0; hz.destEXE = 4'd0;
        hz.wbEnMEM = 1'b1; hz.destMEM = 4'd5;
        check("raw_mem_src2", 1'b1, 1'b0, 1'b0);
        step();
        hz.twoSrc = 1'b0;
        check("raw_src2_unused", 1'b0, 1'b0, 1'b0);
        step();
        hz.twoSrc = 1'b1; hz.wbEnMEM = 1'b0;
        check("raw_mem_no_wb", 1'b0, 1'b0, 1'b0);

        // Branch coincident with a hazard: flush wins.
        step();
        clear_inputs();
        hz.wbEnEXE = 1'b1; hz.destEXE = 4'd5; hz.src1 = 4'd5; hz.branchTaken = 1'b1;
        check("branch_over_hazard", 1'b0, 1'b1, 1'b0);

        // SRAM wait: 4 frozen cycles, release on the ready cycle.
        step();
        clear_inputs();
        hz.memReq = 1'b1;
        check("sram_entry", 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("sram_wait%0d", i), 1'b0, 1'b0, 1'b1);
        end
        step();
        hz.memReady = 1'b1;
        check("sram_ready", 1'b0, 1'b0, 1'b0);
        step();
        clear_inputs();
        check("sram_after", 1'b0, 1'b0, 1'b0);

        // Same-cycle ready: no freeze and the FSM stays in RUN.
        step();
        hz.memReq = 1'b1; hz.memReady = 1'b1;
        check("sram_same_cycle", 1'b0, 1'b0, 1'b0);
        step();
        clear_inputs();
        check("sram_same_cycle_run", 1'b0, 1'b0, 1'b0);

        // Branch and hazard during MEM_WAIT: both suppressed until release.
        step();
        hz.memReq = 1'b1; hz.branchTaken = 1'b1;
        hz.wbEnEXE = 1'b1; hz.destEXE = 4'd5; hz.src1 = 4'd5;
        check("prio_frz_entry", 1'b0, 1'b0, 1'b1);
        step();
        check("prio_frz_wait", 1'b0, 1'b0, 1'b1);
        step();
        hz.memReady = 1'b1;
        check("prio_release", 1'b0, 1'b1, 1'b0);
        step();
        clear_inputs();
        check("prio_after", 1'b0, 1'b0, 1'b0);

        // Timeout: memError appears after 8 MEM_WAIT cycles, freeze holds.
        step();
        hz.memReq = 1'b1;
        check("to_entry", 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 9) exp_err = 1'b1;
            check($sformatf("to_wait%0d", i), 1'b0, 1'b0, 1'b1);
        end

        // Reset mid-wait aborts immediately.
        step();
        rst     = 1'b1;
        sc      = 0;
        fc      = 0;
        exp_err = 1'b0;
        check("to_rst", 1'b0, 1'b0, 1'b0);
        step();
        rst       = 1'b0;
        hz.memReq = 1'b0;
        check("to_after_rst_run", 1'b0, 1'b0, 1'b0);

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
